// File: rtl/gf_inverter.sv
// Modular inverse a^-1 mod p by the binary extended Euclidean algorithm, one step per clock.
// Latency: 1 cycle for rejected operands, 2 for a==1, at most 4*WIDTH+2 cycles in general.
// No backpressure: start is taken only in IDLE; a start seen while busy is dropped.
module gf_inverter #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] Result,
  output logic             done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  state_t           state;
  logic [WIDTH-1:0] u, v, x1, x2, pr;

  // Halve x modulo m: an odd x gets m added first; the sum keeps its carry bit.
  function automatic logic [WIDTH-1:0] mod_half(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[WIDTH:1];
  endfunction

  // (x - y) mod m for x, y already in 0..m-1: add m back when the subtraction borrows.
  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic [WIDTH-1:0] m);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[WIDTH]) d = d + {1'b0, m};
    return d[WIDTH-1:0];
  endfunction

  // Control FSM and datapath: operand latch, one Euclid reduction per RUN cycle, registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      u      <= ZERO;
      v      <= ZERO;
      x1     <= ZERO;
      x2     <= ZERO;
      pr     <= ZERO;
      Result <= ZERO;
      done   <= 1'b0;
      busy   <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            pr   <= p;
            if (a == ZERO || a >= p) begin
              // Out-of-range operand: report immediately without iterating.
              err    <= 1'b1;
              Result <= ZERO;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              u     <= a;
              v     <= p;
              x1    <= ONE;
              x2    <= ZERO;
              err   <= 1'b0;
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (u == ONE) begin
            Result <= x1;
            done   <= 1'b1;
            state  <= DONE;
          end else if (v == ONE) begin
            Result <= x2;
            done   <= 1'b1;
            state  <= DONE;
          end else if (u == ZERO || v == ZERO) begin
            // Only reachable when gcd(a,p) != 1; stop rather than spin.
            err    <= 1'b1;
            Result <= ZERO;
            done   <= 1'b1;
            state  <= DONE;
          end else if (!u[0]) begin
            u  <= u >> 1;
            x1 <= mod_half(x1, pr);
          end else if (!v[0]) begin
            v  <= v >> 1;
            x2 <= mod_half(x2, pr);
          end else if (u >= v) begin
            u  <= u - v;
            x1 <= mod_sub(x1, x2, pr);
          end else begin
            v  <= v - u;
            x2 <= mod_sub(x2, x1, pr);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_inverter.sv
module tb_gf_inverter;
  localparam int W = 256;
  localparam int MAX_LAT = 4 * W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] p = '0;
  logic [W-1:0] Result;
  logic         done, busy, err;

  gf_inverter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .p(p),
    .Result(Result), .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] p;
    logic [W-1:0] res;
    logic         err;
    int           t0;
    int           lat;   // exact latency required, 0 = only the general bound applies
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic prev_done = 1'b0;

  logic [W-1:0] secp, gx, half_secp, ed25519, mersenne31;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic: plain wide multiply and remainder.
  function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] m);
    logic [2*W-1:0] prod;
    prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    prod = prod % {{W{1'b0}}, m};
    return prod[W-1:0];
  endfunction

  // Inverse by Fermat's little theorem: x^(m-2) mod m for prime m.
  function automatic logic [W-1:0] modinv(input logic [W-1:0] x, input logic [W-1:0] m);
    logic [W-1:0] r, b, e;
    r = 1;
    b = x % m;
    e = m - 2;
    for (int i = 0; i < W; i++) begin
      if (e[i]) r = mulmod(r, b, m);
      b = mulmod(b, b, m);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      checks++;
      if (prev_done) begin
        errors++;
        $display("FAIL done_width: done high on two consecutive cycles");
      end
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: Result %h err %b with nothing outstanding", Result, err);
      end else begin
        e = sb.pop_front();
        check("result", Result, e.res);
        check("err", W'(err), W'(e.err));
        check("busy_at_done", W'(busy), W'(1));
        if (e.lat > 0) begin
          check("latency", W'(cyc - e.t0), W'(e.lat));
        end else begin
          checks++;
          if (cyc - e.t0 > MAX_LAT) begin
            errors++;
            $display("FAIL latency_bound: got %0d cycles, limit %0d", cyc - e.t0, MAX_LAT);
          end
        end
        if (!e.err) check("a_times_inv", mulmod(e.a, Result, e.p), W'(1));
      end
    end
    prev_done = done;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 2 * MAX_LAT) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy stuck high");
    end
  endtask

  // Issue one operation; optionally pulse a stray start 'repulse' cycles into the run.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tp,
                        input logic use_const, input logic [W-1:0] cres, input int repulse);
    exp_t e;
    int n;
    wait_idle();
    e.a = ta;
    e.p = tp;
    if (ta == 0 || ta >= tp) begin
      e.err = 1'b1;
      e.res = '0;
      e.lat = 1;
    end else begin
      e.err = 1'b0;
      e.res = use_const ? cres : modinv(ta, tp);
      e.lat = (ta == 1) ? 2 : 0;
    end
    e.t0 = cyc;
    sb.push_back(e);
    a = ta;
    p = tp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = rand_w();
    p = rand_w();
    check("busy_after_start", W'(busy), W'(1));
    n = 0;
    while (sb.size() != 0 && n < MAX_LAT + 10) begin
      if (repulse > 0 && n == repulse) begin
        a = 3;
        p = 7;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles for a=%h", MAX_LAT + 10, ta);
      sb.delete();
    end
  endtask

  initial begin
    logic [W-1:0] pl[6];
    logic [W-1:0] pp, ra;

    secp       = {{192{1'b1}}, 64'hFFFFFFFE_FFFFFC2F};
    gx         = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
    half_secp  = {4'h7, {188{1'b1}}, 64'hFFFFFFFF_7FFFFE18};
    ed25519    = {1'b0, {255{1'b1}}} - 18;
    mersenne31 = 256'h7FFFFFFF;

    repeat (3) @(negedge clk);
    check("reset_result", Result, '0);
    check("reset_done", W'(done), '0);
    check("reset_busy", W'(busy), '0);
    check("reset_err", W'(err), '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(3, 7, 1'b1, 5, 0);
    run_op(1, 7, 1'b1, 1, 0);
    run_op(6, 7, 1'b1, 6, 0);
    run_op(2, secp, 1'b1, half_secp, 0);
    run_op(gx, secp, 1'b0, '0, 0);
    run_op(0, 7, 1'b0, '0, 0);
    run_op(7, 7, 1'b0, '0, 0);
    run_op(secp, secp, 1'b0, '0, 0);
    run_op(gx, secp, 1'b0, '0, 5);

    // Reset in the middle of a long run
    wait_idle();
    a = gx;
    p = secp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrun_reset_result", Result, '0);
    check("midrun_reset_done", W'(done), '0);
    check("midrun_reset_busy", W'(busy), '0);
    check("midrun_reset_err", W'(err), '0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(3, 7, 1'b1, 5, 0);
    run_op(gx, secp, 1'b0, '0, 0);

    // Randomized operands over several primes
    pl[0] = 7; pl[1] = 13; pl[2] = 65521; pl[3] = mersenne31; pl[4] = secp; pl[5] = ed25519;
    for (int i = 0; i < 24; i++) begin
      pp = pl[$urandom_range(0, 5)];
      ra = rand_w() % pp;
      if (i % 8 == 7) ra = pp + W'($urandom_range(0, 3));
      if (pp + 4 < pp) ra = pp;
      run_op(ra, pp, 1'b0, '0, 0);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
